// File: rtl/voice_scheduler.sv
// voice_scheduler: walks the enabled voices once per codec frame, requests one
// sample per voice from the shared synthesis datapath, and mixes the returned
// samples into a saturated 16-bit mono output.
module voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int VOICE_BITS = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_frame,
  input  logic [NUM_VOICES-1:0]   voice_enable,
  output logic                    step_req,
  output logic [VOICE_BITS-1:0]   step_voice,
  input  logic                    step_ack,
  input  logic signed [15:0]      step_sample,
  output logic signed [15:0]      sample_out,
  output logic                    new_sample_generated,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout
);

  localparam int DATA_W = 16;
  localparam int ACC_W  = DATA_W + VOICE_BITS;
  localparam int IDX_W  = VOICE_BITS + 1;
  localparam int CNT_W  = 8;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(VOICE_BITS+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(VOICE_BITS+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_REQ  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          wait_cnt_q, wait_cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      step_req_q, step_req_d;
  logic [VOICE_BITS-1:0]     step_voice_q, step_voice_d;
  logic signed [DATA_W-1:0]  sample_out_q, sample_out_d;
  logic                      nsg_q, nsg_d;
  logic                      overrun_q, overrun_d;
  logic                      timeout_q, timeout_d;

  logic                      scan_last;
  logic                      scan_hit;
  logic                      req_expire;
  logic signed [ACC_W-1:0]   sample_ext;

  // Clamp the wide accumulator into the 16-bit output range.
  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > ACC_MAX) begin
      saturate = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (v < ACC_MIN) begin
      saturate = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      saturate = v[DATA_W-1:0];
    end
  endfunction

  // The scan must test idx == NUM_VOICES before looking at the enable bit,
  // since the low index bits wrap to voice 0 at that point.
  assign scan_last  = (idx_q == LAST_IDX);
  assign scan_hit   = voice_enable[idx_q[VOICE_BITS-1:0]];
  assign req_expire = (wait_cnt_q == TO_LAST);
  assign sample_ext = {{VOICE_BITS{step_sample[DATA_W-1]}}, step_sample};

  // State and datapath registers; reset clears everything, outputs included.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      wait_cnt_q   <= '0;
      acc_q        <= '0;
      step_req_q   <= 1'b0;
      step_voice_q <= '0;
      sample_out_q <= '0;
      nsg_q        <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wait_cnt_q   <= wait_cnt_d;
      acc_q        <= acc_d;
      step_req_q   <= step_req_d;
      step_voice_q <= step_voice_d;
      sample_out_q <= sample_out_d;
      nsg_q        <= nsg_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state logic: one SCAN cycle per voice slot, REQ until ack or expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (new_frame) state_d = S_SCAN;
      S_SCAN: begin
        if (scan_last)     state_d = S_DONE;
        else if (scan_hit) state_d = S_REQ;
      end
      S_REQ:  if (step_ack || req_expire) state_d = S_SCAN;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output updates; ack takes priority over expiry
  // so an ack in the final wait cycle is still accepted.
  always_comb begin
    idx_d        = idx_q;
    wait_cnt_d   = wait_cnt_q;
    acc_d        = acc_q;
    step_req_d   = step_req_q;
    step_voice_d = step_voice_q;
    sample_out_d = sample_out_q;
    nsg_d        = 1'b0;
    timeout_d    = 1'b0;
    overrun_d    = new_frame && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (new_frame) begin
          acc_d = '0;
          idx_d = '0;
        end
      end
      S_SCAN: begin
        if (scan_last) begin
          sample_out_d = saturate(acc_q);
          nsg_d        = 1'b1;
        end else if (scan_hit) begin
          step_voice_d = idx_q[VOICE_BITS-1:0];
          step_req_d   = 1'b1;
          wait_cnt_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_REQ: begin
        if (step_ack) begin
          acc_d      = acc_q + sample_ext;
          step_req_d = 1'b0;
          idx_d      = idx_q + 1'b1;
        end else if (req_expire) begin
          timeout_d  = 1'b1;
          step_req_d = 1'b0;
          idx_d      = idx_q + 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output drive: everything registered except busy, decoded from state.
  always_comb begin
    busy                 = (state_q != S_IDLE);
    step_req             = step_req_q;
    step_voice           = step_voice_q;
    sample_out           = sample_out_q;
    new_sample_generated = nsg_q;
    overrun              = overrun_q;
    timeout              = timeout_q;
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: a reactive datapath responder, a timeline model
// built from the frame rules, and a per-cycle compare process.
module tb_voice_scheduler;

  localparam int NV   = 4;
  localparam int TO   = 8;
  localparam int MAXC = 8192;

  logic               clk = 1'b0;
  logic               reset;
  logic               new_frame;
  logic [NV-1:0]      voice_enable;
  logic               step_req;
  logic [1:0]         step_voice;
  logic               step_ack;
  logic signed [15:0] step_sample;
  logic signed [15:0] sample_out;
  logic               new_sample_generated;
  logic               busy;
  logic               overrun;
  logic               timeout;

  voice_scheduler #(.NUM_VOICES(NV), .VOICE_BITS(2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .new_frame(new_frame), .voice_enable(voice_enable),
    .step_req(step_req), .step_voice(step_voice), .step_ack(step_ack),
    .step_sample(step_sample), .sample_out(sample_out),
    .new_sample_generated(new_sample_generated), .busy(busy),
    .overrun(overrun), .timeout(timeout)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // expected per-slot behaviour
  bit m_busy [MAXC];
  bit m_req  [MAXC];
  bit m_nsg  [MAXC];
  bit m_tout [MAXC];
  bit m_ovr  [MAXC];
  bit m_sset [MAXC];
  int m_voice[MAXC];
  int m_sval [MAXC];

  // per-frame datapath plan: ack delay in cycles after step_req rises (-1 = never)
  bit cfg_en [NV];
  int cfg_dly[NV];
  int cfg_smp[NV];

  // observations of the DUT
  int nsg_count = 0, nsg_slot = -1, last_sout = 0;
  int tout_count = 0, ovr_count = 0, ovr_slot = -1;
  int reqq[$];
  bit prev_dut_req = 1'b0;

  // responder state
  int age = 0;
  bit prev_req = 1'b0;
  int stray_mode = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at slot %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Lay out the whole frame accepted with new_frame in slot s.
  task automatic fill(input int s);
    int t, r, sum;
    t = s + 1;
    sum = 0;
    for (int i = 0; i < NV; i++) begin
      m_busy[t] = 1'b1;
      if (cfg_en[i]) begin
        if (cfg_dly[i] < 0 || cfg_dly[i] >= TO) r = TO;
        else r = cfg_dly[i] + 1;
        for (int k = 1; k <= r; k++) begin
          m_busy[t+k]  = 1'b1;
          m_req[t+k]   = 1'b1;
          m_voice[t+k] = i;
        end
        if (r == cfg_dly[i] + 1) sum += cfg_smp[i];
        else m_tout[t+r+1] = 1'b1;
        t += r + 1;
      end else begin
        t += 1;
      end
    end
    m_busy[t]   = 1'b1;
    m_busy[t+1] = 1'b1;
    m_nsg[t+1]  = 1'b1;
    m_sset[t+1] = 1'b1;
    m_sval[t+1] = clamp16(sum);
  endtask

  task automatic clear_after(input int s);
    for (int t = s + 1; t < s + 120 && t < MAXC; t++) begin
      m_busy[t] = 1'b0; m_req[t] = 1'b0; m_nsg[t] = 1'b0;
      m_tout[t] = 1'b0; m_ovr[t] = 1'b0; m_sset[t] = 1'b0;
    end
    m_sset[s+1] = 1'b1;
    m_sval[s+1] = 0;
  endtask

  // Compare process: check every slot, record observations, advance the model.
  initial begin
    int cur_sout;
    int s;
    cur_sout = 0;
    forever begin
      @(negedge clk);
      s = cyc;
      if (s >= 1 && s < MAXC - 200) begin
        if (m_sset[s]) cur_sout = m_sval[s];
        chk("busy", busy, m_busy[s]);
        chk("step_req", step_req, m_req[s]);
        if (m_req[s]) chk("step_voice", step_voice, m_voice[s]);
        chk("new_sample_generated", new_sample_generated, m_nsg[s]);
        chk("overrun", overrun, m_ovr[s]);
        chk("timeout", timeout, m_tout[s]);
        chk("sample_out", $signed(sample_out), cur_sout);
        if (step_req === 1'b1 && !prev_dut_req) reqq.push_back(int'(step_voice));
        prev_dut_req = (step_req === 1'b1);
        if (new_sample_generated === 1'b1) begin
          nsg_count++;
          nsg_slot  = s;
          last_sout = int'($signed(sample_out));
        end
        if (timeout === 1'b1) tout_count++;
        if (overrun === 1'b1) begin
          ovr_count++;
          ovr_slot = s;
        end
        if (reset) clear_after(s);
        else if (new_frame) begin
          if (m_busy[s]) m_ovr[s+1] = 1'b1;
          else fill(s);
        end
      end
    end
  end

  // Advance one cycle and drive the datapath side reactively.
  task automatic tick();
    @(posedge clk);
    #1;
    new_frame = 1'b0;
    if (step_req === 1'b1) age = prev_req ? age + 1 : 0;
    prev_req = (step_req === 1'b1);
    if (prev_req && cfg_dly[step_voice] >= 0 && age == cfg_dly[step_voice]) begin
      step_ack    = 1'b1;
      step_sample = 16'(cfg_smp[step_voice]);
    end else if (!prev_req && (stray_mode == 2 || (stray_mode == 1 && $urandom_range(3) == 0))) begin
      step_ack    = 1'b1;
      step_sample = 16'sh5a5a;
    end else begin
      step_ack    = 1'b0;
      step_sample = 16'($urandom);
    end
  endtask

  task automatic set_cfg(input logic [3:0] en, input int d0, d1, d2, d3,
                         input int s0, s1, s2, s3);
    for (int i = 0; i < NV; i++) cfg_en[i] = en[i];
    cfg_dly[0] = d0; cfg_dly[1] = d1; cfg_dly[2] = d2; cfg_dly[3] = d3;
    cfg_smp[0] = s0; cfg_smp[1] = s1; cfg_smp[2] = s2; cfg_smp[3] = s3;
    voice_enable = en;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("idle_bound", busy, 0);
  endtask

  task automatic run_frame(output int s);
    new_frame = 1'b1;
    s = cyc;
    tick();
    wait_idle();
  endtask

  initial begin
    int s, nb, ob, tb0, n;
    logic signed [15:0] r16;
    int rs[NV], rd[NV];
    reset = 1'b1; new_frame = 1'b0; step_ack = 1'b0; step_sample = '0;
    voice_enable = '0;
    set_cfg(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_sample_out", $signed(sample_out), 0);
    chk("reset_step_req", step_req, 0);

    // basic mix
    set_cfg(4'b1111, 0, 0, 0, 0, 1000, 2000, 3000, 4000);
    reqq.delete(); nb = nsg_count;
    run_frame(s);
    chk("basic_sum", last_sout, 10000);
    chk("basic_done_slot", nsg_slot, s + 10);
    chk("basic_pulses", nsg_count - nb, 1);
    chk("basic_nreq", reqq.size(), 4);
    for (int i = 0; i < reqq.size() && i < 4; i++) chk("basic_voice_order", reqq[i], i);

    // saturation
    stray_mode = 1;
    set_cfg(4'b1111, 0, 1, 0, 2, 20000, 20000, 20000, 20000);
    run_frame(s);
    chk("sat_pos", last_sout, 32767);
    set_cfg(4'b1111, 0, 0, 0, 0, -20000, -20000, -20000, -20000);
    run_frame(s);
    chk("sat_neg", last_sout, -32768);
    set_cfg(4'b1111, 0, 0, 0, 0, 32767, -32768, 0, 0);
    run_frame(s);
    chk("sat_mixed", last_sout, -1);
    set_cfg(4'b1111, 0, 0, 0, 0, 32767, 32767, -32768, -32768);
    run_frame(s);
    chk("no_intermediate_clip", last_sout, -2);

    // no voices enabled
    set_cfg(4'b0000, 0, 0, 0, 0, 5, 5, 5, 5);
    nb = nsg_count;
    run_frame(s);
    chk("none_sum", last_sout, 0);
    chk("none_slot", nsg_slot, s + 6);
    chk("none_pulses", nsg_count - nb, 1);

    // sparse enable, ack three cycles after request
    stray_mode = 0;
    set_cfg(4'b0101, 3, 3, 3, 3, 500, 7, -200, 9);
    reqq.delete();
    run_frame(s);
    chk("sparse_sum", last_sout, 300);
    chk("sparse_done_slot", nsg_slot, s + 14);
    chk("sparse_nreq", reqq.size(), 2);
    if (reqq.size() == 2) begin
      chk("sparse_voice0", reqq[0], 0);
      chk("sparse_voice1", reqq[1], 2);
    end

    // overrun mid-frame
    set_cfg(4'b1111, 0, 0, 0, 0, 1000, 2000, 3000, 4000);
    nb = nsg_count; ob = ovr_count;
    new_frame = 1'b1;
    s = cyc;
    repeat (4) tick();
    new_frame = 1'b1;
    tick();
    wait_idle();
    repeat (3) tick();
    chk("overrun_slot", ovr_slot, s + 5);
    chk("overrun_count", ovr_count - ob, 1);
    chk("overrun_one_frame", nsg_count - nb, 1);

    // overrun in the DONE cycle
    nb = nsg_count; ob = ovr_count;
    new_frame = 1'b1;
    s = cyc;
    repeat (10) tick();
    chk("done_cycle_pulse", new_sample_generated, 1);
    new_frame = 1'b1;
    tick();
    chk("done_drop_overrun", overrun, 1);
    repeat (4) tick();
    chk("done_drop_idle", busy, 0);
    chk("done_drop_frames", nsg_count - nb, 1);
    chk("done_drop_overruns", ovr_count - ob, 1);

    // timeout with late acks everywhere outside REQ
    stray_mode = 2;
    set_cfg(4'b1111, 0, -1, 0, 0, 100, 100, 100, 100);
    tb0 = tout_count;
    run_frame(s);
    stray_mode = 0;
    chk("timeout_sum", last_sout, 300);
    chk("timeout_pulses", tout_count - tb0, 1);

    // reset while a request is outstanding
    set_cfg(4'b1111, 5, 5, 5, 5, 11, 22, 33, 44);
    new_frame = 1'b1;
    tick();
    n = 0;
    while (step_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("reset_reached_req", step_req, 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_step_req", step_req, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_sample_out", $signed(sample_out), 0);
    set_cfg(4'b1111, 0, 0, 0, 0, 1000, 2000, 3000, 4000);
    run_frame(s);
    chk("after_reset_sum", last_sout, 10000);
    chk("after_reset_slot", nsg_slot, s + 10);

    // randomized frames with stray acks, dropped frames and occasional resets
    stray_mode = 1;
    for (int f = 0; f < 60; f++) begin
      for (int i = 0; i < NV; i++) begin
        n = $urandom_range(11);
        rd[i] = (n == 11) ? -1 : n;
        r16 = 16'($urandom);
        if ($urandom_range(5) == 0) r16 = ($urandom_range(1) == 0) ? 16'sh7fff : 16'sh8000;
        rs[i] = int'(r16);
      end
      set_cfg(4'($urandom), rd[0], rd[1], rd[2], rd[3], rs[0], rs[1], rs[2], rs[3]);
      new_frame = 1'b1;
      tick();
      n = 0;
      while (busy === 1'b1 && n < 300) begin
        if ($urandom_range(14) == 0) new_frame = 1'b1;
        if ($urandom_range(79) == 0) reset = 1'b1;
        tick();
        reset = 1'b0;
        n++;
      end
      if (n >= 300) chk("rand_bound", busy, 0);
      repeat ($urandom_range(3)) tick();
    end
    stray_mode = 0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
